scan_sequencer: RTL and testbench

Sequences one IR/temperature scan sweep. It steps the servo angle across a programmable range, waits for the mechanics to settle, requests one sensor sample, and writes that sample into cell memory through a request/grant write port. It sits between servo_pwm (drives its angle), the I2C temperature reader (sample handshake), and a memory_manager write requester (shared with the core). Sweeps ping-pong (up, then down) for as long as enable is high.

---
 rtl/scan_sequencer_if.sv | 34 +++
 rtl/scan_sequencer.sv | 165 ++++++++++++++++
 tb/tb_scan_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/scan_sequencer_if.sv
// Sample handshake and memory write port
// shared by the scan sequencer and its peers.
interface scan_sequencer_if;
  logic        sample_req;
  logic        sample_ack;
  logic [15:0] sample_data;
  logic        mem_req;
  logic        mem_grant;
  logic [23:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;

  modport master (
    output sample_req,
    input  sample_ack,
    input  sample_data,
    output mem_req,
    input  mem_grant,
    output mem_addr,
    output mem_data,
    output mem_we
  );

  modport slave (
    input  sample_req,
    output sample_ack,
    output sample_data,
    input  mem_req,
    output mem_grant,
    input  mem_addr,
    input  mem_data,
    input  mem_we
  );
endinterface

// File: rtl/scan_sequencer.sv
// Ping-pong servo sweep: settle, sample,
// write one cell per angle step.
module scan_sequencer #(
  parameter int unsigned ANGLE_MIN      = 0,
  parameter int unsigned ANGLE_MAX      = 180,
  parameter int unsigned ANGLE_STEP     = 15,
  parameter int unsigned SETTLE_CYCLES  = 25_000_000,
  parameter int unsigned SAMPLE_TIMEOUT = 1_000_000,
  parameter logic [23:0] BASE_ADDR      = 24'h00_F000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [15:0]      angle,
  scan_sequencer_if.master bus,
  output logic             busy,
  output logic             sweep_done,
  output logic             timeout_flag
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    WRITE,
    NEXT
  } state_t;

  // Zero-length waits degrade to one cycle.
  localparam logic [31:0] SETTLE_LOAD =
    (SETTLE_CYCLES == 0) ? 32'd0 :
    32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] SAMPLE_LOAD =
    (SAMPLE_TIMEOUT == 0) ? 32'd0 :
    32'(SAMPLE_TIMEOUT - 1);

  localparam logic [16:0] A_MIN  = 17'(ANGLE_MIN);
  localparam logic [16:0] A_MAX  = 17'(ANGLE_MAX);
  localparam logic [16:0] A_STEP = 17'(ANGLE_STEP);
  localparam logic [15:0] STEP16 = 16'(ANGLE_STEP);
  localparam bit          SPAN0  =
    (ANGLE_MAX == ANGLE_MIN);

  state_t      state;
  logic [31:0] timer;
  logic [15:0] index;
  logic        dir_up;
  logic        sample_req;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [15:0] mem_data;

  logic        at_top;
  logic        at_bot;
  logic        reverse;
  logic        move_up;

  assign bus.sample_req = sample_req;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_req;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_data   = mem_data;

  // Range-edge detection for the next step.
  always_comb begin
    at_top  = ({1'b0, angle} + A_STEP) > A_MAX;
    at_bot  = {1'b0, angle} < (A_MIN + A_STEP);
    reverse = dir_up ? at_top : at_bot;
    move_up = dir_up ? !at_top : at_bot;
  end

  // Sweep FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      timer        <= '0;
      index        <= '0;
      dir_up       <= 1'b1;
      angle        <= 16'(ANGLE_MIN);
      sample_req   <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_data     <= '0;
      busy         <= 1'b0;
      sweep_done   <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state <= SETTLE;
            timer <= SETTLE_LOAD;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (timer == '0) begin
            state      <= SAMPLE;
            timer      <= SAMPLE_LOAD;
            sample_req <= 1'b1;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        SAMPLE: begin
          // Ack beats a same-cycle timeout.
          if (bus.sample_ack) begin
            state      <= WRITE;
            sample_req <= 1'b0;
            mem_req    <= 1'b1;
            mem_addr   <= BASE_ADDR
                        + {8'd0, index};
            mem_data   <= bus.sample_data;
          end else if (timer == '0) begin
            state        <= WRITE;
            sample_req   <= 1'b0;
            mem_req      <= 1'b1;
            mem_addr     <= BASE_ADDR
                          + {8'd0, index};
            mem_data     <= 16'hFFFF;
            timeout_flag <= 1'b1;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        WRITE: begin
          if (bus.mem_grant) begin
            state   <= NEXT;
            mem_req <= 1'b0;
          end
        end
        NEXT: begin
          if (reverse) begin
            dir_up     <= !dir_up;
            sweep_done <= 1'b1;
          end
          if (!SPAN0) begin
            if (move_up) begin
              angle <= angle + STEP16;
              index <= index + 16'd1;
            end else begin
              angle <= angle - STEP16;
              index <= index - 16'd1;
            end
          end
          if (enable) begin
            state <= SETTLE;
            timer <= SETTLE_LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          sample_req <= 1'b0;
          mem_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer:
// sweep order, stalls, timeout, enable, reset.
module tb_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] angle;
  logic        busy;
  logic        sweep_done;
  logic        timeout_flag;

  int checks = 0;
  int errors = 0;
  int writes = 0;

  scan_sequencer_if io ();

  scan_sequencer #(
    .ANGLE_MIN      (0),
    .ANGLE_MAX      (180),
    .ANGLE_STEP     (90),
    .SETTLE_CYCLES  (4),
    .SAMPLE_TIMEOUT (8),
    .BASE_ADDR      (24'h000100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .angle        (angle),
    .bus          (io.master),
    .busy         (busy),
    .sweep_done   (sweep_done),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (reset && io.mem_req && io.mem_grant)
      writes <= writes + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string t);
    chk({t, "_angle"}, 32'(angle), 0);
    chk({t, "_req"}, 32'(io.sample_req), 0);
    chk({t, "_mreq"}, 32'(io.mem_req), 0);
    chk({t, "_mwe"}, 32'(io.mem_we), 0);
    chk({t, "_busy"}, 32'(busy), 0);
    chk({t, "_done"}, 32'(sweep_done), 0);
    chk({t, "_tflag"}, 32'(timeout_flag), 0);
    chk({t, "_addr"}, 32'(io.mem_addr), 32'h100);
    chk({t, "_data"}, 32'(io.mem_data), 0);
  endtask

  // One full step: settle, sample, write, next.
  task automatic step(
    input int          exp_wait,
    input logic [15:0] ang,
    input logic [23:0] addr,
    input logic [15:0] d,
    input bit          no_ack,
    input int          gdelay,
    input bit          done,
    input logic [15:0] nang,
    input bit          tf
  );
    int cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!io.sample_req && cnt < 100);
    chk("req_wait", 32'(cnt), 32'(exp_wait));
    chk("angle", 32'(angle), 32'(ang));
    chk("busy", 32'(busy), 1);
    if (no_ack) begin
      repeat (7) begin
        @(negedge clk);
        chk("req_hold", 32'(io.sample_req), 1);
      end
      @(negedge clk);
    end else begin
      @(negedge clk);
      chk("req_hold", 32'(io.sample_req), 1);
      io.sample_ack  = 1'b1;
      io.sample_data = d;
      @(negedge clk);
      io.sample_ack  = 1'b0;
      io.sample_data = 16'h5555;
    end
    chk("req_fall", 32'(io.sample_req), 0);
    chk("mem_req", 32'(io.mem_req), 1);
    chk("mem_we", 32'(io.mem_we), 1);
    chk("mem_addr", 32'(io.mem_addr), 32'(addr));
    chk("mem_data", 32'(io.mem_data), 32'(d));
    chk("tflag", 32'(timeout_flag), 32'(tf));
    repeat (gdelay) begin
      @(negedge clk);
      chk("stall_req", 32'(io.mem_req), 1);
      chk("stall_addr", 32'(io.mem_addr),
          32'(addr));
      chk("stall_data", 32'(io.mem_data),
          32'(d));
    end
    io.mem_grant = 1'b1;
    @(negedge clk);
    io.mem_grant = 1'b0;
    chk("req_drop", 32'(io.mem_req), 0);
    chk("we_drop", 32'(io.mem_we), 0);
    chk("done_early", 32'(sweep_done), 0);
    @(negedge clk);
    chk("done", 32'(sweep_done), 32'(done));
    chk("next_angle", 32'(angle), 32'(nang));
    @(negedge clk);
    chk("done_width", 32'(sweep_done), 0);
  endtask

  initial begin
    int cnt;
    reset          = 1'b1;
    enable         = 1'b0;
    io.sample_ack  = 1'b0;
    io.sample_data = '0;
    io.mem_grant   = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    enable = 1'b1;

    // Basic ping-pong sweep.
    step(5, 0,   24'h100, 16'h0A00,
         0, 0, 0, 90,  0);
    step(3, 90,  24'h101, 16'h0A01,
         0, 0, 0, 180, 0);
    step(3, 180, 24'h102, 16'h0A02,
         0, 0, 1, 90,  0);
    step(3, 90,  24'h101, 16'h0A01,
         0, 0, 0, 0,   0);
    step(3, 0,   24'h100, 16'h0A00,
         0, 0, 1, 90,  0);

    // Grant withheld for 10 cycles.
    step(3, 90,  24'h101, 16'h0B01,
         0, 10, 0, 180, 0);

    // Sample timeout, then sticky flag.
    step(3, 180, 24'h102, 16'hFFFF,
         1, 0, 1, 90,  1);
    step(3, 90,  24'h101, 16'h0C01,
         0, 0, 0, 0,   1);
    step(3, 0,   24'h100, 16'h0C00,
         0, 0, 1, 90,  1);

    // Enable dropped during settle at 90.
    enable = 1'b0;
    step(3, 90,  24'h101, 16'h0D01,
         0, 0, 0, 180, 1);
    chk("off_busy", 32'(busy), 0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (io.sample_req) cnt++;
    end
    chk("off_reqs", 32'(cnt), 0);
    chk("off_angle", 32'(angle), 180);

    // Resume at 180, reverses downward.
    enable = 1'b1;
    step(5, 180, 24'h102, 16'h0D02,
         0, 0, 1, 90,  1);

    // Reset while write pending.
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!io.sample_req && cnt < 100);
    chk("t6_req", 32'(io.sample_req), 1);
    @(negedge clk);
    io.sample_ack  = 1'b1;
    io.sample_data = 16'h0E01;
    @(negedge clk);
    io.sample_ack  = 1'b0;
    chk("t6_mreq", 32'(io.mem_req), 1);
    chk("t6_addr", 32'(io.mem_addr), 32'h101);
    repeat (2) @(negedge clk);
    chk("t6_hold", 32'(io.mem_req), 1);
    reset = 1'b0;
    #1;
    chk_reset_outs("arst");
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_mreq", 32'(io.mem_req), 0);
    chk("post_req", 32'(io.sample_req), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_angle", 32'(angle), 0);
    chk("write_count", 32'(writes), 11);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
